z16_register_file: RTL and testbench
====================================

Name: z16_register_file

Overview:
- Z16 general-purpose register file and operand-fetch stage; sits directly upstream of the Z16 ALU.
- Holds 16 x 16-bit registers, with R0 hardwired to zero.
- Reads two source registers on request and presents them as registered operands: o_data_a feeds the ALU A input, o_data_b feeds the ALU B input.
- Accepts one write-back per cycle and forwards a same-cycle write to the operand outputs.

Parameters:
- DATA_W, 16, register and operand width
- REG_NUM, 16, number of registers; address width is log2(REG_NUM) = 4
- ZERO_R0, 1, when 1 register 0 reads as 0 and ignores writes

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst  input  1  synchronous, active-high reset
- i_rd_en  input  1  operand-fetch request this cycle
- i_stall  input  1  downstream stall; hold the operand outputs
- i_rs_a  input  4  source register index for operand A
- i_rs_b  input  4  source register index for operand B
- i_we  input  1  write-back enable
- i_wr_addr  input  4  write-back destination index
- i_wr_data  input  16  write-back data
- o_data_a  output  16  registered operand A (to ALU i_data_a)
- o_data_b  output  16  registered operand B (to ALU i_data_b)
- o_valid  output  1  operands on o_data_a/o_data_b are fresh and valid
- i_dbg_addr  input  4  debug read index
- o_dbg_data  output  16  combinational debug read of the register array (no bypass)

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - all 16 registers, o_data_a, o_data_b and o_valid become 0 on that edge
  - overrides i_we, i_rd_en and i_stall in the same cycle
  - reset asserted mid-fetch discards the pending operands
- Write:
  - when i_we=1 and i_rst=0, reg[i_wr_addr] <= i_wr_data at the edge
  - when i_wr_addr=0 and ZERO_R0=1, the write is dropped
- Fetch, one-cycle latency:
  - when i_rd_en=1 and i_stall=0, at the edge: o_data_a <= read(i_rs_a), o_data_b <= read(i_rs_b), o_valid <= 1
  - when i_rd_en=0 and i_stall=0: o_valid <= 0; o_data_a/o_data_b hold their last values
- Stall:
  - when i_stall=1 (and i_rst=0), o_data_a, o_data_b and o_valid hold regardless of i_rd_en; the request is not captured
  - the upstream stage must hold its request until the stall releases
  - writes still occur during a stall
- read(x):
  - 0 if x=0 and ZERO_R0=1
  - otherwise i_wr_data if i_we=1 and i_wr_addr=x (write-through bypass)
  - otherwise reg[x]
- Both sources equal to the write address: both operands take the bypassed data.
- i_rs_a = i_rs_b: both outputs carry the same value.
- Stale-operand case:
  - a write to a register already latched while o_valid is held under stall does not update the held operands
  - operands reflect register state at capture time; hazard handling belongs to the pipeline controller
- o_dbg_data = reg[i_dbg_addr] from array state only, with no bypass; reads 0 for index 0 when ZERO_R0=1.
- All arithmetic is DATA_W wide with no sign handling; the block only stores and moves data.

Test Plan:
- Reset then fetch: assert i_rst 2 cycles, then fetch rs_a=5, rs_b=9 -> o_data_a=0, o_data_b=0, o_valid=1 one cycle later; o_dbg_data=0 for all indices.
- Write/read back and R0: write R3=16'h1234, then R0=16'hFFFF; next cycle fetch rs_a=3, rs_b=0 -> o_data_a=16'h1234, o_data_b=16'h0000; o_dbg_data(0)=0.
- Bypass: same cycle i_we=1, i_wr_addr=7, i_wr_data=16'hBEEF, i_rd_en=1, rs_a=7, rs_b=7 -> both operands 16'hBEEF next cycle, while o_dbg_data(7) shows the old value in the write cycle.
- Stall hold: fetch R3=16'h1234, then stall 3 cycles with i_rd_en=1, rs_a=4 and a write R3=16'h5555 -> o_data_a stays 16'h1234 and o_valid stays 1 during the stall; fetch after release gives 16'h5555.
- Valid drop: fetch one cycle, then i_rd_en=0 -> o_valid 1 then 0; data holds.
- Reset mid-operation: i_rst with i_we=1 (R2=16'hAAAA) and i_rd_en=1 in the same cycle -> R2=0, o_valid=0, o_data_a=o_data_b=0.

Source files
------------

// File: rtl/z16_register_file.sv
// Z16 register file and operand-fetch stage: 16 x 16-bit registers, two registered
// read ports with write-through bypass, one write-back port and a combinational debug read.
module z16_register_file #(
    parameter int DATA_W  = 16,
    parameter int REG_NUM = 16,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(REG_NUM)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rd_en,
    input  logic              i_stall,
    input  logic [AW-1:0]     i_rs_a,
    input  logic [AW-1:0]     i_rs_b,
    input  logic              i_we,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_data_a,
    output logic [DATA_W-1:0] o_data_b,
    output logic              o_valid,
    input  logic [AW-1:0]     i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              wr_ok;

    assign wr_ok = i_we && !((ZERO_R0 != 0) && (i_wr_addr == '0));

    // Read ports: R0 forced to zero first, then same-cycle write bypass, then array.
    always_comb begin
        rd_a = regs_q[i_rs_a];
        rd_b = regs_q[i_rs_b];
        if (i_we && (i_wr_addr == i_rs_a)) rd_a = i_wr_data;
        if (i_we && (i_wr_addr == i_rs_b)) rd_b = i_wr_data;
        if ((ZERO_R0 != 0) && (i_rs_a == '0)) rd_a = '0;
        if ((ZERO_R0 != 0) && (i_rs_b == '0)) rd_b = '0;
    end

    // Stall freezes everything on the output side; an idle cycle only drops valid.
    always_comb begin
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        valid_d  = valid_q;
        if (!i_stall) begin
            valid_d = i_rd_en;
            if (i_rd_en) begin
                data_a_d = rd_a;
                data_b_d = rd_b;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (wr_ok) regs_q[i_wr_addr] <= i_wr_data;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            valid_q  <= valid_d;
        end
    end

    assign o_data_a   = data_a_q;
    assign o_data_b   = data_b_q;
    assign o_valid    = valid_q;
    assign o_dbg_data = ((ZERO_R0 != 0) && (i_dbg_addr == '0)) ? '0 : regs_q[i_dbg_addr];

endmodule

// File: tb/tb_z16_register_file.sv
// Bench for z16_register_file: directed scenarios followed by random traffic, all
// checked against an array-based model of the register file and operand latch.
module tb_z16_register_file;

    logic        i_clk;
    logic        i_rst;
    logic        i_rd_en;
    logic        i_stall;
    logic [3:0]  i_rs_a;
    logic [3:0]  i_rs_b;
    logic        i_we;
    logic [3:0]  i_wr_addr;
    logic [15:0] i_wr_data;
    logic [15:0] o_data_a;
    logic [15:0] o_data_b;
    logic        o_valid;
    logic [3:0]  i_dbg_addr;
    logic [15:0] o_dbg_data;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_regs [16];
    logic [15:0] m_a, m_b;
    logic        m_v;

    z16_register_file dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rd_en    (i_rd_en),
        .i_stall    (i_stall),
        .i_rs_a     (i_rs_a),
        .i_rs_b     (i_rs_b),
        .i_we       (i_we),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .o_data_a   (o_data_a),
        .o_data_b   (o_data_b),
        .o_valid    (o_valid),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [3:0] x);
        if (x == 4'd0) return 16'h0000;
        if (i_we && i_wr_addr == x) return i_wr_data;
        return m_regs[x];
    endfunction

    task automatic drive(input logic rst, input logic rd, input logic stall,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic [3:0] dbg);
        i_rst = rst; i_rd_en = rd; i_stall = stall; i_rs_a = ra; i_rs_b = rb;
        i_we = we; i_wr_addr = wa; i_wr_data = wd; i_dbg_addr = dbg;
    endtask

    // Inputs are already applied; check debug port pre-edge, advance model, clock, check outputs.
    task automatic cycle();
        #1;
        check("dbg", o_dbg_data, (i_dbg_addr == 4'd0) ? 16'h0000 : m_regs[i_dbg_addr]);
        if (i_rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
            m_a = 16'h0000; m_b = 16'h0000; m_v = 1'b0;
        end else begin
            if (!i_stall) begin
                m_v = i_rd_en;
                if (i_rd_en) begin
                    m_a = m_read(i_rs_a);
                    m_b = m_read(i_rs_b);
                end
            end
            if (i_we && i_wr_addr != 4'd0) m_regs[i_wr_addr] = i_wr_data;
        end
        @(posedge i_clk);
        #1;
        check("data_a", o_data_a, m_a);
        check("data_b", o_data_b, m_b);
        check("valid", {15'd0, o_valid}, {15'd0, m_v});
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        m_a = 16'h0000; m_b = 16'h0000; m_v = 1'b0;

        // Reset two cycles, then fetch R5/R9 from a cleared file.
        drive(1, 1, 0, 4'd1, 4'd2, 1, 4'd6, 16'h7777, 4'd0); @(posedge i_clk); #1;
        drive(1, 0, 0, 4'd0, 4'd0, 0, 4'd0, 16'h0000, 4'd0); cycle();
        check("rst_valid", {15'd0, o_valid}, 16'h0000);
        drive(0, 1, 0, 4'd5, 4'd9, 0, 4'd0, 16'h0000, 4'd0); cycle();
        check("rst_fetch_a", o_data_a, 16'h0000);
        check("rst_fetch_v", {15'd0, o_valid}, 16'h0001);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 4'd0, 4'd0, 0, 4'd0, 16'h0000, 4'(i)); cycle();
        end

        // Write R3, attempt R0, then read both back.
        drive(0, 0, 0, 4'd0, 4'd0, 1, 4'd3, 16'h1234, 4'd3); cycle();
        drive(0, 0, 0, 4'd0, 4'd0, 1, 4'd0, 16'hFFFF, 4'd0); cycle();
        drive(0, 1, 0, 4'd3, 4'd0, 0, 4'd0, 16'h0000, 4'd0); cycle();
        check("r3_a", o_data_a, 16'h1234);
        check("r0_b", o_data_b, 16'h0000);

        // Same-cycle bypass on both ports; debug shows the old R7 in the write cycle.
        drive(0, 1, 0, 4'd7, 4'd7, 1, 4'd7, 16'hBEEF, 4'd7); cycle();
        check("byp_a", o_data_a, 16'hBEEF);
        check("byp_b", o_data_b, 16'hBEEF);

        // Fetch R3, stall three cycles while R3 is rewritten, then release.
        drive(0, 1, 0, 4'd3, 4'd3, 0, 4'd0, 16'h0000, 4'd3); cycle();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1, 4'd4, 4'd4, 1, 4'd3, 16'h5555, 4'd3); cycle();
            check("stall_a", o_data_a, 16'h1234);
            check("stall_v", {15'd0, o_valid}, 16'h0001);
        end
        drive(0, 1, 0, 4'd3, 4'd3, 0, 4'd0, 16'h0000, 4'd3); cycle();
        check("post_stall_a", o_data_a, 16'h5555);

        // Valid drops when the request goes away; data holds.
        drive(0, 0, 0, 4'd7, 4'd7, 0, 4'd0, 16'h0000, 4'd0); cycle();
        check("drop_v", {15'd0, o_valid}, 16'h0000);
        check("drop_hold", o_data_a, 16'h5555);

        // Reset overrides a simultaneous write and fetch.
        drive(0, 0, 0, 4'd0, 4'd0, 1, 4'd2, 16'h1111, 4'd0); cycle();
        drive(0, 1, 0, 4'd2, 4'd3, 0, 4'd0, 16'h0000, 4'd0); cycle();
        drive(1, 1, 0, 4'd2, 4'd3, 1, 4'd2, 16'hAAAA, 4'd2); cycle();
        check("midrst_v", {15'd0, o_valid}, 16'h0000);
        check("midrst_a", o_data_a, 16'h0000);
        drive(0, 0, 0, 4'd0, 4'd0, 0, 4'd0, 16'h0000, 4'd2); cycle();

        // Random traffic with a small index range to force bypass and aliasing.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) == 0),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
                  16'($urandom), 4'($urandom_range(0, 15)));
            if (n % 2 == 0) begin
                i_rs_a = 4'($urandom_range(0, 3));
                i_wr_addr = 4'($urandom_range(0, 3));
                i_rs_b = i_rs_a;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
